// File: rtl/div_seq_pkg.sv
// Shared definitions for the divide-counter sequencer.
// Holds the FSM state encoding, table geometry, the field layout of a
// table entry and a helper that turns a stored repeat count into the
// number of toggles that finishes an entry.
package div_seq_pkg;

    // Number of table entries (power of two) and the matching index width.
    localparam int DEPTH = 8;
    localparam int IDX_W = $clog2(DEPTH);

    // Table entry layout: [15:8] repeat count, [7:0] divide value.
    localparam int ENTRY_W = 16;
    localparam int REP_MSB = 15;
    localparam int REP_LSB = 8;
    localparam int VAL_MSB = 7;
    localparam int VAL_LSB = 0;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // A stored repeat count of zero stands for 256 toggles, so the target
    // needs one bit more than the stored field.
    function automatic logic [8:0] rep_target(input logic [7:0] rep);
        logic [8:0] tgt;
        if (rep == 8'd0) begin
            tgt = 9'd256;
        end else begin
            tgt = {1'b0, rep};
        end
        return tgt;
    endfunction

endpackage

// File: rtl/div_seq_table.sv
// Entry table for the divide-counter sequencer.
// DEPTH x WIDTH register file, deliberately without reset: contents are
// undefined until the host writes them.
// Ports:
//   clk    in   system clock
//   we     in   write strobe (synchronous write)
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index (asynchronous read)
//   rdata  out  entry at raddr
module div_seq_table #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Host write port; writes are accepted in every sequencer state.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/div_sequencer.sv
// Controller that steps the ice40 programmable divide/toggle counter
// through a table of (divide value, repeat count) entries.
// While an entry is active its divide value is presented with restart
// held high; toggles of the counter output are counted and, once the
// programmed number is reached, the next entry is loaded. The sequence
// ends after last_idx, or wraps to entry 0 when loop was set at start.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   cfg_we       in   table write strobe
//   cfg_addr     in   table write index
//   cfg_data     in   [15:8] repeat count, [7:0] divide value
//   last_idx     in   final entry index, captured on accepted start
//   loop         in   wrap after last_idx, captured on accepted start
//   start        in   request to begin a sequence (ignored while busy)
//   stop         in   request to abort (wins over start)
//   div_out      in   toggle output of the divide counter
//   div_value    out  divide value driven to the counter
//   div_restart  out  restart/run enable driven to the counter
//   busy         out  sequence in progress
//   done         out  one-cycle pulse on natural completion
//   cur_idx      out  entry currently loaded
module div_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [15:0]              cfg_data,
    input  logic [$clog2(DEPTH)-1:0] last_idx,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     div_out,
    output logic [7:0]               div_value,
    output logic                     div_restart,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] cur_idx
);

    import div_seq_pkg::*;

    localparam int IW = $clog2(DEPTH);

    // Registered state
    state_t                state_r;
    logic [IW-1:0]         idx_r;
    logic [7:0]            rep_r;
    logic [8:0]            tog_cnt_r;
    logic                  div_out_q_r;
    logic [IW-1:0]         last_idx_r;
    logic                  loop_r;

    // Next-state values
    state_t                state_s;
    logic [IW-1:0]         idx_s;
    logic [7:0]            rep_s;
    logic [8:0]            tog_cnt_s;
    logic [IW-1:0]         last_idx_s;
    logic                  loop_s;
    logic [7:0]            div_value_s;
    logic                  div_restart_s;
    logic                  busy_s;
    logic                  done_s;
    logic [IW-1:0]         cur_idx_s;

    // Helpers
    logic [ENTRY_W-1:0]    entry_s;
    logic                  edge_s;
    logic [8:0]            tog_inc_s;
    logic                  entry_end_s;

    div_seq_table #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_table (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (idx_r),
        .rdata (entry_s)
    );

    // Any change of the counter output since last cycle is one toggle.
    assign edge_s      = div_out ^ div_out_q_r;
    assign tog_inc_s   = tog_cnt_r + 9'd1;
    assign entry_end_s = (tog_inc_s == rep_target(rep_r));

    // Next-state and next-output decode for the sequencer FSM.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        rep_s         = rep_r;
        tog_cnt_s     = tog_cnt_r;
        last_idx_s    = last_idx_r;
        loop_s        = loop_r;
        div_value_s   = div_value;
        div_restart_s = div_restart;
        cur_idx_s     = cur_idx;
        done_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                div_restart_s = 1'b0;
                // stop has priority over a simultaneous start.
                if (start && !stop) begin
                    last_idx_s = last_idx;
                    loop_s     = loop;
                    idx_s      = {IW{1'b0}};
                    state_s    = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_LOAD: begin
                // The only cycle the table is read; toggles seen here are
                // not counted towards the new entry.
                if (stop) begin
                    div_restart_s = 1'b0;
                    state_s       = ST_IDLE;
                end else begin
                    div_value_s   = entry_s[VAL_MSB:VAL_LSB];
                    rep_s         = entry_s[REP_MSB:REP_LSB];
                    tog_cnt_s     = 9'd0;
                    cur_idx_s     = idx_r;
                    div_restart_s = 1'b1;
                    state_s       = ST_RUN;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    div_restart_s = 1'b0;
                    state_s       = ST_IDLE;
                end else if (edge_s) begin
                    tog_cnt_s = tog_inc_s;
                    if (entry_end_s) begin
                        if (idx_r != last_idx_r) begin
                            idx_s   = idx_r + IW'(1);
                            state_s = ST_LOAD;
                        end else if (loop_r) begin
                            idx_s   = {IW{1'b0}};
                            state_s = ST_LOAD;
                        end else begin
                            div_restart_s = 1'b0;
                            done_s        = 1'b1;
                            state_s       = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end

            default: begin
                div_restart_s = 1'b0;
                state_s       = ST_IDLE;
            end
        endcase

        // busy is registered from the next state so it tracks LOAD/RUN
        // without a combinational path from the inputs.
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IW{1'b0}};
            rep_r       <= 8'd0;
            tog_cnt_r   <= 9'd0;
            div_out_q_r <= 1'b0;
            last_idx_r  <= {IW{1'b0}};
            loop_r      <= 1'b0;
            div_value   <= 8'd0;
            div_restart <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cur_idx     <= {IW{1'b0}};
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            rep_r       <= rep_s;
            tog_cnt_r   <= tog_cnt_s;
            div_out_q_r <= div_out;
            last_idx_r  <= last_idx_s;
            loop_r      <= loop_s;
            div_value   <= div_value_s;
            div_restart <= div_restart_s;
            busy        <= busy_s;
            done        <= done_s;
            cur_idx     <= cur_idx_s;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer. The stimulus side walks the table
// model to predict the sequence of entries (value, index, toggle count)
// and the terminating event; the monitor extracts the same events from
// the DUT outputs and counts the counter toggles the DUT could see.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [2:0]  last_idx;
    logic        loop;
    logic        start;
    logic        stop;
    logic        div_out;
    logic [7:0]  div_value;
    logic        div_restart;
    logic        busy;
    logic        done;
    logic [2:0]  cur_idx;

    div_sequencer #(.DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .last_idx    (last_idx),
        .loop        (loop),
        .start       (start),
        .stop        (stop),
        .div_out     (div_out),
        .div_value   (div_value),
        .div_restart (div_restart),
        .busy        (busy),
        .done        (done),
        .cur_idx     (cur_idx)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_SEG = 0, EV_DONE = 1, EV_STOP = 2} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] val;
        logic [2:0] idx;
        int         reps;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] mdl_tab [8];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          gen_period = 0;
    int          gen_cnt = 0;

    // monitor state
    logic        m_restart = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dout = 1'b0;
    logic [7:0]  m_val = 8'd0;
    logic [2:0]  m_idx = 3'd0;
    logic        m_e_next = 1'b0;
    logic        m_e_prev = 1'b0;
    logic        m_e_now = 1'b0;
    bit          m_active = 1'b0;
    int          m_cnt = 0;
    int          m_reps = 0;
    ev_t         m_ev;
    bit          m_ok;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int reps_of(input logic [15:0] e);
        int r;
        r = int'(e[15:8]);
        return (r == 0) ? 256 : r;
    endfunction

    task automatic push_seg(input int i);
        ev_t e;
        e.kind = EV_SEG;
        e.val  = mdl_tab[i][7:0];
        e.idx  = 3'(i);
        e.reps = reps_of(mdl_tab[i]);
        exp_q.push_back(e);
    endtask

    task automatic push_kind(input ev_kind_t k);
        ev_t e;
        e.kind = k;
        e.val  = 8'd0;
        e.idx  = 3'd0;
        e.reps = 0;
        exp_q.push_back(e);
    endtask

    // One-shot: entries 0..last then done. Looping: nseg entries then stop.
    task automatic push_run(input int last, input bit lp, input int nseg);
        if (!lp) begin
            for (int i = 0; i <= last; i++) push_seg(i);
            push_kind(EV_DONE);
        end else begin
            for (int i = 0; i < nseg; i++) push_seg(i % (last + 1));
            push_kind(EV_STOP);
        end
    endtask

    // ---------------- counter model: toggles div_out every gen_period cycles
    initial begin
        div_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_period > 0) begin
                gen_cnt++;
                if (gen_cnt >= gen_period) begin
                    gen_cnt = 0;
                    div_out = ~div_out;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic pop_ev(output ev_t e, output bit ok);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: DUT produced an event, scoreboard empty (t=%0t)", $time);
            ok = 1'b0;
            e.kind = EV_SEG; e.val = 8'd0; e.idx = 3'd0; e.reps = 0;
        end else begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic close_seg(input logic last_e);
        check("seg_edge_count", m_cnt, m_reps);
        check("seg_final_edge", int'(last_e), 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            m_e_now = m_e_next;
            if (div_restart && (!m_restart || div_value != m_val || cur_idx != m_idx)) begin
                if (m_active) close_seg(m_e_prev);
                pop_ev(m_ev, m_ok);
                if (m_ok) begin
                    check("seg_kind", int'(div_restart ? EV_SEG : EV_STOP), int'(m_ev.kind));
                    check("seg_div_value", int'(div_value), int'(m_ev.val));
                    check("seg_cur_idx", int'(cur_idx), int'(m_ev.idx));
                    m_reps = m_ev.reps;
                end
                m_cnt    = 0;
                m_active = 1'b1;
            end else begin
                if (m_active && m_e_now) m_cnt++;
                if (done) begin
                    if (m_active) close_seg(m_e_now);
                    pop_ev(m_ev, m_ok);
                    if (m_ok) check("done_expected", int'(EV_DONE), int'(m_ev.kind));
                    check("done_busy", int'(busy), 0);
                    check("done_restart", int'(div_restart), 0);
                    check("done_single_cycle", int'(m_done), 0);
                    m_active = 1'b0;
                end else if (!busy && m_busy) begin
                    pop_ev(m_ev, m_ok);
                    if (m_ok) check("stop_expected", int'(EV_STOP), int'(m_ev.kind));
                    check("stop_restart", int'(div_restart), 0);
                    m_active = 1'b0;
                end
            end
            m_e_next  = (div_out != m_dout);
            m_dout    = div_out;
            m_e_prev  = m_e_now;
            m_restart = div_restart;
            m_busy    = busy;
            m_done    = done;
            m_val     = div_value;
            m_idx     = cur_idx;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cfg_w(input int a, input logic [15:0] d);
        mdl_tab[a] = d;
        @(posedge clk);
        #1;
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] li, input logic lp, input bit chk, input logic [7:0] v0);
        @(posedge clk);
        #1;
        last_idx = li;
        loop     = lp;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        last_idx = 3'($urandom);
        loop     = 1'($urandom);
        if (chk) begin
            @(negedge clk);
            check("start_busy_k", int'(busy), 1);
            check("start_restart_k", int'(div_restart), 0);
            @(negedge clk);
            check("start_restart_k1", int'(div_restart), 1);
            check("start_value_k1", int'(div_value), int'(v0));
        end
    endtask

    task automatic wait_q(input int level, input int lim);
        int t;
        t = 0;
        while (exp_q.size() > level && t < lim) begin
            @(negedge clk);
            t++;
        end
        check("wait_q_timeout", (exp_q.size() > level) ? 1 : 0, 0);
        if (exp_q.size() > level) exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_div_value"}, int'(div_value), 0);
        check({tag, "_div_restart"}, int'(div_restart), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_cur_idx"}, int'(cur_idx), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int t;
        int last;
        rst_n = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 16'd0;
        last_idx = 3'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_done", int'(done), 0);
        check("reset_release_busy", int'(busy), 0);

        // one-shot, start ignored while busy, back-to-back start in done cycle
        cfg_w(0, {8'd2, 8'd3});
        cfg_w(1, {8'd1, 8'd5});
        gen_period = 4;
        push_run(1, 1'b0, 0);
        push_run(1, 1'b0, 0);
        do_start(3'd1, 1'b0, 1'b1, 8'd3);
        wait_q(5, 200);
        @(posedge clk);
        #1;
        start = 1'b1; last_idx = 3'd7; loop = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; last_idx = 3'd0; loop = 1'b0;
        t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("first_done_seen", int'(done), 1);
        start = 1'b1; last_idx = 3'd1; loop = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_q(0, 500);
        check("oneshot_hold_idx", int'(cur_idx), 1);
        check("oneshot_hold_value", int'(div_value), 5);

        // start and stop together: stays idle
        @(posedge clk);
        #1;
        start = 1'b1; stop = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("startstop_busy", int'(busy), 0);
            check("startstop_restart", int'(div_restart), 0);
        end

        // loop for 3 laps, then stop during lap 4 entry 0
        push_run(1, 1'b1, 7);
        do_start(3'd1, 1'b1, 1'b0, 8'd0);
        wait_q(1, 600);
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        check("stop_latency_busy", int'(busy), 0);
        check("stop_latency_restart", int'(div_restart), 0);
        check("stop_cur_idx", int'(cur_idx), 0);
        wait_q(0, 10);

        // repeat count 0 = 256 toggles, toggling every cycle (incl. LOAD)
        cfg_w(0, {8'd0, 8'd1});
        gen_period = 1;
        push_run(0, 1'b0, 0);
        do_start(3'd0, 1'b0, 1'b1, 8'd1);
        wait_q(0, 600);

        // write to the active entry while running, then async reset mid-run
        cfg_w(0, {8'd2, 8'd3});
        gen_period = 4;
        push_seg(0);
        do_start(3'd1, 1'b1, 1'b1, 8'd3);
        wait_q(0, 50);
        mdl_tab[0] = {8'd2, 8'd9};
        push_seg(1);
        push_seg(0);
        push_kind(EV_STOP);
        cfg_w(0, {8'd2, 8'd9});
        wait_q(1, 300);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset_midrun");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_midrun_release_done", int'(done), 0);
        wait_q(0, 5);

        // randomized one-shot sequences
        for (int r = 0; r < 6; r++) begin
            last = int'($urandom_range(0, 7));
            for (int i = 0; i <= last; i++)
                cfg_w(i, {8'($urandom_range(1, 4)), 8'($urandom)});
            gen_period = int'($urandom_range(1, 4));
            push_run(last, 1'b0, 0);
            do_start(3'(last), 1'b0, 1'b1, mdl_tab[0][7:0]);
            wait_q(0, 2000);
            repeat (2) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
